// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the program loader.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STEP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/prog_step_counter.sv
// Run-length down-counter: loads a cycle budget and counts down, saturating at zero.
module prog_step_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    output logic              zero,
    output logic              last
);

    logic [STEP_W-1:0] count_q;

    // Count register: load has priority, decrement never wraps below zero.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - STEP_W'(1);
        end
    end

    // Flags derived from the current count.
    always_comb begin
        zero = (count_q == '0);
        last = (count_q == STEP_W'(1));
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then gates the processor clock for a run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              start,
    input  logic [STEP_W-1:0] step_count,
    input  logic              halt,
    input  logic              clear_err,
    output logic              write_ins,
    output logic [ADDR_W-1:0] ins_address,
    output logic [DATA_W-1:0] ins,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   loaded_count,
    output logic              err_ovf
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [ADDR_W-1:0] wr_idx;
    logic              ovf_hit;
    logic              start_ok;
    logic              cnt_zero;
    logic              cnt_last;

    // Run-length counter: loaded on an accepted start, ticks down every RUN cycle.
    prog_step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (step_count),
        .dec      (state_q == ST_RUN),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Handshake, write index and start qualification.
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        s_ready  = 1'b0;
        accept   = 1'b0;
        wr_idx   = '0;
        ovf_hit  = 1'b0;
        start_ok = 1'b0;
        // An IDLE accept restarts the program at index 0, so a full previous
        // program does not block it; in LOAD the word count is the limit.
        if (!err_ovf) begin
            if (state_q == ST_IDLE) begin
                s_ready = 1'b1;
            end else if (state_q == ST_LOAD) begin
                s_ready = (loaded_count < DEPTH_CNT);
            end
        end
        accept = s_valid && s_ready;
        if (state_q == ST_LOAD) begin
            wr_idx = loaded_count[ADDR_W-1:0];
        end
        ovf_hit  = accept && !s_last && (wr_idx == LAST_IDX);
        // A word accepted in the same IDLE cycle takes precedence over start.
        start_ok = (state_q == ST_IDLE) && start && !accept &&
                   (loaded_count != '0) && !err_ovf;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!s_last && !ovf_hit) begin
                        state_d = ST_LOAD;
                    end
                end else if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (accept && (s_last || ovf_hit)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                cpu_en = 1'b1;
                // A zero count means free-run; only halt ends it. Halt and the
                // final counted cycle both lead to the same single DONE.
                if (halt || (!cnt_zero && cnt_last)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction-memory write port, word count and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ins    <= 1'b0;
            ins_address  <= '0;
            ins          <= '0;
            loaded_count <= '0;
            err_ovf      <= 1'b0;
        end else begin
            write_ins <= accept;
            if (accept) begin
                ins_address  <= wr_idx;
                ins          <= s_data;
                loaded_count <= {1'b0, wr_idx} + (ADDR_W + 1)'(1);
            end
            if (ovf_hit) begin
                err_ovf <= 1'b1;
            end else if (clear_err) begin
                err_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with default parameters.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        start;
    logic [15:0] step_count;
    logic        halt;
    logic        clear_err;
    logic        write_ins;
    logic [4:0]  ins_address;
    logic [31:0] ins;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic [5:0]  loaded_count;
    logic        err_ovf;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog [4] = '{32'hF2800004, 32'hF2801008, 32'hF6010000, 32'hFAFFFFFB};

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .start        (start),
        .step_count   (step_count),
        .halt         (halt),
        .clear_err    (clear_err),
        .write_ins    (write_ins),
        .ins_address  (ins_address),
        .ins          (ins),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .done         (done),
        .loaded_count (loaded_count),
        .err_ovf      (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},      32'(s_ready),      32'd1);
        check({tag, "_write_ins"},    32'(write_ins),    32'd0);
        check({tag, "_ins_address"},  32'(ins_address),  32'd0);
        check({tag, "_ins"},          ins,               32'd0);
        check({tag, "_cpu_en"},       32'(cpu_en),       32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_loaded_count"}, 32'(loaded_count), 32'd0);
        check({tag, "_err_ovf"},      32'(err_ovf),      32'd0);
    endtask

    // Start a run and watch 40 cycles; halt_at > 0 raises halt during that enabled cycle.
    task automatic run_prog(input logic [15:0] n, input int halt_at,
                            output int en_cnt, output int done_cnt);
        en_cnt     = 0;
        done_cnt   = 0;
        step_count = n;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cpu_en) en_cnt++;
            if (done) done_cnt++;
            halt = (halt_at != 0) && cpu_en && (en_cnt == halt_at);
            tick();
        end
        halt = 1'b0;
    endtask

    initial begin
        int en_cnt;
        int done_cnt;
        int wr_cnt;
        logic [4:0]  last_addr;
        logic [31:0] last_data;

        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        start      = 1'b0;
        step_count = '0;
        halt       = 1'b0;
        clear_err  = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Start with nothing loaded is ignored
        step_count = 16'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start_cpu_en", 32'(cpu_en), 32'd0);
        check("empty_start_busy",   32'(busy),   32'd0);
        tick();

        // Load a four-word program
        for (int i = 0; i < 4; i++) begin
            check($sformatf("load%0d_s_ready", i), 32'(s_ready), 32'd1);
            s_valid = 1'b1;
            s_data  = prog[i];
            s_last  = (i == 3);
            tick();
            check($sformatf("load%0d_write_ins", i), 32'(write_ins), 32'd1);
            check($sformatf("load%0d_addr", i), 32'(ins_address), 32'(i));
            check($sformatf("load%0d_data", i), ins, prog[i]);
            check($sformatf("load%0d_count", i), 32'(loaded_count), 32'(i + 1));
            check($sformatf("load%0d_busy", i), 32'(busy), (i == 3) ? 32'd0 : 32'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        check("load_write_idle", 32'(write_ins), 32'd0);
        check("load_final_count", 32'(loaded_count), 32'd4);

        // Counted run of 14 cycles
        run_prog(16'd14, 0, en_cnt, done_cnt);
        check("run14_en_cycles", 32'(en_cnt), 32'd14);
        check("run14_done_pulses", 32'(done_cnt), 32'd1);
        check("run14_idle_busy", 32'(busy), 32'd0);
        check("run14_retained_count", 32'(loaded_count), 32'd4);

        // Free-run stopped by halt on the 7th cycle
        run_prog(16'd0, 7, en_cnt, done_cnt);
        check("free_halt_en_cycles", 32'(en_cnt), 32'd7);
        check("free_halt_done_pulses", 32'(done_cnt), 32'd1);

        // Halt coinciding with the final counted cycle
        run_prog(16'd5, 5, en_cnt, done_cnt);
        check("halt_last_en_cycles", 32'(en_cnt), 32'd5);
        check("halt_last_done_pulses", 32'(done_cnt), 32'd1);

        // Start and word in the same IDLE cycle: the load wins
        s_valid    = 1'b1;
        s_data     = 32'hA5A50001;
        s_last     = 1'b1;
        start      = 1'b1;
        step_count = 16'd3;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        check("collide_write_ins", 32'(write_ins), 32'd1);
        check("collide_addr", 32'(ins_address), 32'd0);
        check("collide_data", ins, 32'hA5A50001);
        check("collide_count", 32'(loaded_count), 32'd1);
        check("collide_cpu_en", 32'(cpu_en), 32'd0);
        tick();
        check("collide_cpu_en_later", 32'(cpu_en), 32'd0);
        check("collide_busy_later", 32'(busy), 32'd0);

        // Stream 33+ words without s_last: only 32 written, overflow flagged
        wr_cnt    = 0;
        last_addr = '0;
        last_data = '0;
        s_valid   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_data = 32'h1000 + 32'(k);
            tick();
            if (write_ins) begin
                wr_cnt++;
                last_addr = ins_address;
                last_data = ins;
            end
        end
        check("ovf_writes", 32'(wr_cnt), 32'd32);
        check("ovf_last_addr", 32'(last_addr), 32'd31);
        check("ovf_last_data", last_data, 32'h101F);
        check("ovf_err", 32'(err_ovf), 32'd1);
        check("ovf_s_ready", 32'(s_ready), 32'd0);
        check("ovf_count", 32'(loaded_count), 32'd32);
        s_valid = 1'b0;

        // Start is refused while the overflow flag is set
        step_count = 16'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("ovf_start_cpu_en", 32'(cpu_en), 32'd0);
        tick();

        // clear_err restores acceptance without touching the count
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_err_flag", 32'(err_ovf), 32'd0);
        check("clear_err_s_ready", 32'(s_ready), 32'd1);
        check("clear_err_count", 32'(loaded_count), 32'd32);

        // Reset in the 5th cycle of a run
        step_count = 16'd20;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midrun_cpu_en_before", 32'(cpu_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("midrun_rst");
        tick();
        check("midrun_rst_done_held", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        check("midrun_after_done", 32'(done), 32'd0);
        check("midrun_after_cpu_en", 32'(cpu_en), 32'd0);
        check("midrun_after_count", 32'(loaded_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
